// File: rtl/maxpool_flatten.sv
// rtl/maxpool_flatten.sv - 2x2 stride-2 max-pool of two L0 maps into L1 maps and interleaved L2 flatten
// Outputs are registered from the next state so each bus cycle lines up with its FSM state.
module maxpool_flatten #(
    parameter int DATA_W = 20,
    parameter int IN_DIM = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_crd,
    output logic [11:0]       o_caddr_rd,
    input  logic [DATA_W-1:0] i_cdata_rd,
    output logic              o_cwr,
    output logic [11:0]       o_caddr_wr,
    output logic [DATA_W-1:0] o_cdata_wr,
    output logic [2:0]        o_csel
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int LOG_OUT = $clog2(OUT_DIM);
    localparam int IDX_W   = 2 * LOG_OUT;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [11:0] ROW_OFF = 12'(IN_DIM);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WL1, S_WL2, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_k, w_k_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_max;
    logic [LOG_OUT-1:0] w_row, w_col;
    logic [11:0]        w_base;

    assign w_row  = w_idx_nxt[IDX_W-1:LOG_OUT];
    assign w_col  = w_idx_nxt[LOG_OUT-1:0];
    // Top-left of the window: (2r)*IN_DIM + 2c
    assign w_base = (12'(w_row) << (LOG_OUT + 2)) | (12'(w_col) << 1);

    assign w_max = ((r_state == S_RD0) || ($signed(i_cdata_rd) > $signed(r_acc)))
                   ? i_cdata_rd : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RD0;
                    w_idx_nxt   = '0;
                    w_k_nxt     = 1'b0;
                end
            end
            S_RD0: w_state_nxt = S_RD1;
            S_RD1: w_state_nxt = S_RD2;
            S_RD2: w_state_nxt = S_RD3;
            S_RD3: w_state_nxt = S_WL1;
            S_WL1: w_state_nxt = S_WL2;
            S_WL2: begin
                if ((r_idx == LAST_IDX) && r_k) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RD0;
                    w_k_nxt     = ~r_k;
                    if (r_k) begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_k        <= 1'b0;
            r_acc      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_crd      <= 1'b0;
            o_cwr      <= 1'b0;
            o_caddr_rd <= '0;
            o_caddr_wr <= '0;
            o_cdata_wr <= '0;
            o_csel     <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_k     <= w_k_nxt;
            if (r_state inside {S_RD0, S_RD1, S_RD2, S_RD3}) begin
                r_acc <= w_max;
            end
            o_busy <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE));
            o_done <= (w_state_nxt == S_DONE);
            o_crd  <= 1'b0;
            o_cwr  <= 1'b0;
            o_csel <= 3'b000;
            case (w_state_nxt)
                S_RD0, S_RD1, S_RD2, S_RD3: begin
                    o_crd  <= 1'b1;
                    o_csel <= 3'd1 + {2'b00, w_k_nxt};
                    case (w_state_nxt)
                        S_RD0:   o_caddr_rd <= w_base;
                        S_RD1:   o_caddr_rd <= w_base + 12'd1;
                        S_RD2:   o_caddr_rd <= w_base + ROW_OFF;
                        default: o_caddr_rd <= w_base + ROW_OFF + 12'd1;
                    endcase
                end
                S_WL1: begin
                    // Entered only from RD3, so w_max already folds in the last read
                    o_cwr      <= 1'b1;
                    o_csel     <= 3'd3 + {2'b00, w_k_nxt};
                    o_caddr_wr <= 12'(w_idx_nxt);
                    o_cdata_wr <= w_max;
                end
                S_WL2: begin
                    o_cwr      <= 1'b1;
                    o_csel     <= 3'd5;
                    o_caddr_wr <= 12'({w_idx_nxt, w_k_nxt});
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_flatten.sv
// tb/tb_maxpool_flatten.sv - scoreboard bench for maxpool_flatten with a falling-edge memory model
module tb_maxpool_flatten;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, crd, cwr;
    logic [11:0]   ard, awr;
    logic [DW-1:0] drd = '0;
    logic [DW-1:0] dwr;
    logic [2:0]    csel;

    logic [DW-1:0] l0 [2][4096];
    logic [DW-1:0] l1 [2][1024];
    logic [DW-1:0] l2 [2048];

    logic [36:0] exp_q [$];
    int n_tests = 0;
    int n_fail = 0;
    int tick = 0;
    int e0 = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_wr = -1;

    maxpool_flatten #(.DATA_W(DW), .IN_DIM(64)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_crd      (crd),
        .o_caddr_rd (ard),
        .i_cdata_rd (drd),
        .o_cwr      (cwr),
        .o_caddr_wr (awr),
        .o_cdata_wr (dwr),
        .o_csel     (csel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor and memory: samples strobes on the falling edge, as the real memory does
    always @(negedge clk) begin
        logic [36:0] obs;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = tick - e0 + 1;
        end
        if (crd || cwr) begin
            obs = {cwr, crd, csel, (cwr ? awr : ard), (cwr ? dwr : {DW{1'b0}})};
            if (exp_q.size() == 0) check("sb_extra", {27'd0, obs}, 64'd0);
            else check("bus", {27'd0, obs}, {27'd0, exp_q.pop_front()});
        end
        if (cwr && csel == 3'd3 && awr == 12'd0 && (tick - e0 + 1) <= 8) first_wr = tick - e0 + 1;
        if (crd) begin
            if (csel == 3'd1) drd = l0[0][ard];
            else if (csel == 3'd2) drd = l0[1][ard];
            else drd = '0;
        end
        if (cwr) begin
            if (csel == 3'd3) l1[0][awr[9:0]] = dwr;
            else if (csel == 3'd4) l1[1][awr[9:0]] = dwr;
            else if (csel == 3'd5) l2[awr[10:0]] = dwr;
        end
    end

    task automatic fill_mem();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 4096; a++) l0[k][a] = DW'($urandom);
        l0[0][0] = 20'h00010; l0[0][1] = 20'h00050; l0[0][64] = 20'h00030; l0[0][65] = 20'h00020;
        l0[1][0] = 20'h00011; l0[1][1] = 20'h00051; l0[1][64] = 20'h00031; l0[1][65] = 20'h00021;
        l0[0][2] = 20'h00000; l0[0][3] = 20'hFFFF0; l0[0][66] = 20'hFFF00; l0[0][67] = 20'h80000;
        l0[1][2] = 20'hFFFF0; l0[1][3] = 20'hFFF00; l0[1][66] = 20'h80000; l0[1][67] = 20'hFFFFF;
    endtask

    task automatic push_expected();
        int offs [4];
        int a;
        logic signed [DW-1:0] m, v;
        offs = '{0, 1, 64, 65};
        for (int i = 0; i < 1024; i++) begin
            a = (i / 32) * 128 + (i % 32) * 2;
            for (int k = 0; k < 2; k++) begin
                m = l0[k][a];
                for (int j = 0; j < 4; j++) begin
                    v = l0[k][a + offs[j]];
                    if (v > m) m = v;
                    exp_q.push_back({1'b0, 1'b1, 3'(1 + k), 12'(a + offs[j]), 20'd0});
                end
                exp_q.push_back({1'b1, 1'b0, 3'(3 + k), 12'(i), m});
                exp_q.push_back({1'b1, 1'b0, 3'd5, 12'(2 * i + k), m});
            end
        end
    endtask

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = tick;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 13000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int b0, d0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {13'd0, busy, done, crd, cwr, ard, awr, dwr, csel}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Pass 1: full run with a stray start at cycle 100
        push_expected();
        b0 = busy_cnt;
        d0 = done_cnt;
        start_pass();
        while (tick - e0 + 1 < 99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("busy_cycles", 64'(busy_cnt - b0), 64'd12288);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'd12289);
        check("first_l1_cycle", 64'(first_wr), 64'd5);
        check("sb_left", 64'(exp_q.size()), 64'd0);
        check("busy_after", {63'd0, busy}, 64'd0);
        check("l1k0_0", 64'(l1[0][0]), 64'h00050);
        check("l2_0", 64'(l2[0]), 64'h00050);
        check("l1k1_0", 64'(l1[1][0]), 64'h00051);
        check("l2_1", 64'(l2[1]), 64'h00051);
        check("signed_mix", 64'(l1[0][1]), 64'h00000);
        check("signed_mix_l2", 64'(l2[2]), 64'h00000);
        check("all_neg", 64'(l1[1][1]), 64'hFFFFF);
        check("all_neg_l2", 64'(l2[3]), 64'hFFFFF);

        // Pass 2: abort with an asynchronous reset at cycle 5000
        push_expected();
        start_pass();
        while (tick - e0 + 1 < 5000) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {13'd0, busy, done, crd, cwr, ard, awr, dwr, csel}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_idle", {62'd0, busy, crd | cwr}, 64'd0);
        end

        // Pass 3: restart after the abort
        fill_mem();
        push_expected();
        b0 = busy_cnt;
        d0 = done_cnt;
        start_pass();
        wait_done();
        repeat (3) @(negedge clk);
        check("busy_cycles2", 64'(busy_cnt - b0), 64'd12288);
        check("done_pulses2", 64'(done_cnt - d0), 64'd1);
        check("sb_left2", 64'(exp_q.size()), 64'd0);
        check("all_neg2", 64'(l2[3]), 64'hFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
